tmr_unit: RTL and testbench

- Memory-mapped 16-bit timer/counter peripheral that sits beside the single-cycle MIPS datapath.
- Consumes the control word the register file exports on tmr_ctrl.
- Produces the tmr_cntr and tmr_overflow values that the datapath reads back.
- Provides a programmable prescaler, periodic (auto-reload) and one-shot modes, and a sticky overflow flag with software clear.

---
 rtl/tmr_unit.sv | 129 ++++++++++++
 tb/tb_tmr_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/tmr_unit.sv
// 16-bit memory-mapped timer: prescaler, periodic / one-shot modes,
// sticky overflow flag with edge-triggered software clear.
module tmr_unit #(
    parameter int CNT_W = 16,
    parameter int PS_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      tmr_ctrl,
    output logic [CNT_W-1:0] tmr_cntr,
    output logic             tmr_overflow,
    output logic             ovf_pulse,
    output logic             busy
);

    localparam int PW = 2**PS_W - 1;
    localparam logic [PW-1:0]    P_ONE = 1;
    localparam logic [CNT_W-1:0] C_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cntr;
    logic [CNT_W-1:0] w_cntr_nxt;
    logic [PW-1:0]    r_p;
    logic [PW-1:0]    w_p_nxt;
    logic             r_ovf;
    logic             w_ovf_nxt;
    logic             r_pulse;
    logic             r_busy;
    logic             r_clr_q;

    logic             w_en;
    logic             w_ar;
    logic             w_clr;
    logic [PS_W-1:0]  w_ps;
    logic [CNT_W-1:0] w_period;
    logic [PW-1:0]    w_lim;
    logic             w_tick;
    logic             w_ovf_evt;
    logic             w_clr_rise;
    logic             w_unused;

    assign w_en     = tmr_ctrl[0];
    assign w_ar     = tmr_ctrl[1];
    assign w_clr    = tmr_ctrl[2];
    assign w_ps     = tmr_ctrl[4 +: PS_W];
    assign w_period = tmr_ctrl[16 +: CNT_W];
    assign w_unused = ^{tmr_ctrl[15:8], tmr_ctrl[3]};

    // Modular arithmetic: at PS = 15 the shift wraps to 0, giving all-ones.
    assign w_lim      = (P_ONE << w_ps) - P_ONE;
    assign w_tick     = (r_state == S_RUN) && (r_p == w_lim);
    assign w_ovf_evt  = w_tick && w_en && (r_cntr >= w_period);
    assign w_clr_rise = w_clr && !r_clr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cntr  <= '0;
            r_p     <= '0;
            r_ovf   <= 1'b0;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
            r_clr_q <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cntr  <= w_cntr_nxt;
            r_p     <= w_p_nxt;
            r_ovf   <= w_ovf_nxt;
            r_pulse <= w_ovf_evt;
            r_busy  <= (w_state_nxt == S_RUN);
            r_clr_q <= w_clr;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (w_en) w_state_nxt = S_RUN;
            S_RUN: begin
                if (!w_en)
                    w_state_nxt = S_IDLE;
                else if (w_ovf_evt && !w_ar)
                    w_state_nxt = S_DONE;
            end
            S_DONE: if (!w_en) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_cntr_nxt = r_cntr;
        w_p_nxt    = '0;
        unique case (r_state)
            S_IDLE: w_cntr_nxt = '0;
            S_RUN: begin
                if (!w_en) begin
                    w_cntr_nxt = '0;
                end else begin
                    w_p_nxt = w_tick ? '0 : r_p + P_ONE;
                    if (w_ovf_evt)
                        w_cntr_nxt = w_ar ? '0 : r_cntr;
                    else if (w_tick)
                        w_cntr_nxt = r_cntr + C_ONE;
                end
            end
            default: w_cntr_nxt = r_cntr;
        endcase
        // Set beats a simultaneous clear.
        if (w_ovf_evt)
            w_ovf_nxt = 1'b1;
        else if (w_clr_rise)
            w_ovf_nxt = 1'b0;
        else
            w_ovf_nxt = r_ovf;
    end

    assign tmr_cntr     = r_cntr;
    assign tmr_overflow = r_ovf;
    assign ovf_pulse    = r_pulse;
    assign busy         = r_busy;

endmodule

// File: tb/tb_tmr_unit.sv
// Directed bench for tmr_unit: reset, periodic, prescaled one-shot,
// clear semantics, period shrink, EN drop, PERIOD = 0.
module tb_tmr_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] tmr_ctrl;
    logic [15:0] tmr_cntr;
    logic        tmr_overflow;
    logic        ovf_pulse;
    logic        busy;

    int errs = 0;
    int checks = 0;

    tmr_unit dut (
        .clk          (clk),
        .reset        (reset),
        .tmr_ctrl     (tmr_ctrl),
        .tmr_cntr     (tmr_cntr),
        .tmr_overflow (tmr_overflow),
        .ovf_pulse    (ovf_pulse),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(
        input logic en, input logic ar, input logic clr,
        input logic [3:0] ps, input logic [15:0] per);
        return {per, 8'h00, ps, 1'b0, clr, ar, en};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int npulse;
        reset    = 1'b1;
        tmr_ctrl = '0;
        step(2);
        reset = 1'b0;
        chk("rst_cntr", tmr_cntr, 0);
        chk("rst_ovf", tmr_overflow, 0);
        chk("rst_pulse", ovf_pulse, 0);
        chk("rst_busy", busy, 0);

        // reset mid-count
        tmr_ctrl = mk(1, 1, 0, 0, 5);
        step(1);
        chk("mid_busy", busy, 1);
        step(2);
        chk("mid_cntr", tmr_cntr, 2);
        reset = 1'b1;
        step(1);
        chk("mid_rst_cntr", tmr_cntr, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ovf", tmr_overflow, 0);
        chk("mid_rst_pulse", ovf_pulse, 0);
        reset    = 1'b0;
        tmr_ctrl = '0;
        step(1);

        // periodic PERIOD = 3
        tmr_ctrl = mk(1, 1, 0, 0, 3);
        step(1);
        chk("per_start", tmr_cntr, 0);
        for (int k = 0; k < 8; k++) begin
            step(1);
            chk("per_cntr", tmr_cntr, (k + 1) % 4);
            chk("per_pulse", ovf_pulse, ((k + 1) % 4) == 0);
            chk("per_ovf", tmr_overflow, k >= 3);
        end
        tmr_ctrl = '0;
        step(1);
        chk("per_off_busy", busy, 0);
        chk("per_off_cntr", tmr_cntr, 0);
        chk("per_off_ovf", tmr_overflow, 1);
        tmr_ctrl = mk(0, 0, 1, 0, 0);
        step(1);
        chk("clr_basic", tmr_overflow, 0);
        tmr_ctrl = '0;
        step(1);

        // prescaled one-shot PS = 2, PERIOD = 2
        tmr_ctrl = mk(1, 0, 0, 2, 2);
        step(1);
        npulse = 0;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            if (ovf_pulse) npulse++;
            chk("os_cntr", tmr_cntr, (i < 12) ? i / 4 : 2);
        end
        chk("os_pulse12", ovf_pulse, 1);
        chk("os_busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (ovf_pulse) npulse++;
        end
        chk("os_npulse", npulse, 1);
        chk("os_hold", tmr_cntr, 2);
        chk("os_ovf", tmr_overflow, 1);
        tmr_ctrl = mk(0, 0, 0, 2, 2);
        step(1);
        tmr_ctrl = mk(1, 0, 0, 2, 2);
        step(1);
        chk("os_restart_cntr", tmr_cntr, 0);
        chk("os_restart_busy", busy, 1);
        step(4);
        chk("os_restart_adv", tmr_cntr, 1);
        tmr_ctrl = '0;
        step(1);

        // CLR held high: single clear, later overflow re-sets
        tmr_ctrl = mk(1, 1, 1, 0, 3);
        step(1);
        chk("hold_clr", tmr_overflow, 0);
        step(4);
        chk("hold_pulse", ovf_pulse, 1);
        chk("hold_reset", tmr_overflow, 1);
        step(5);
        chk("hold_stays", tmr_overflow, 1);
        chk("hold_cntr", tmr_cntr, 1);
        tmr_ctrl = mk(1, 1, 0, 0, 3);
        step(2);
        chk("same_pre", tmr_cntr, 3);
        tmr_ctrl = mk(1, 1, 1, 0, 3);
        step(1);
        chk("same_pulse", ovf_pulse, 1);
        chk("same_ovf", tmr_overflow, 1);
        tmr_ctrl = mk(1, 1, 0, 0, 3);
        step(1);
        tmr_ctrl = mk(1, 1, 1, 0, 3);
        step(1);
        chk("late_clr", tmr_overflow, 0);
        chk("late_cntr", tmr_cntr, 2);
        tmr_ctrl = '0;
        step(1);

        // period shrink 100 -> 10 at count 50
        tmr_ctrl = mk(1, 1, 0, 0, 100);
        step(51);
        chk("shr_50", tmr_cntr, 50);
        tmr_ctrl = mk(1, 1, 0, 0, 10);
        step(1);
        chk("shr_cntr", tmr_cntr, 0);
        chk("shr_pulse", ovf_pulse, 1);
        step(1);
        chk("shr_next", tmr_cntr, 1);
        chk("shr_pulse_off", ovf_pulse, 0);
        tmr_ctrl = mk(0, 0, 1, 0, 0);
        step(1);
        chk("shr_clr", tmr_overflow, 0);
        tmr_ctrl = '0;
        step(1);

        // EN drop coincident with terminal tick
        tmr_ctrl = mk(1, 1, 0, 0, 2);
        step(3);
        chk("en_pre", tmr_cntr, 2);
        tmr_ctrl = mk(0, 1, 0, 0, 2);
        step(1);
        chk("en_pulse", ovf_pulse, 0);
        chk("en_busy", busy, 0);
        chk("en_cntr", tmr_cntr, 0);
        chk("en_ovf", tmr_overflow, 0);
        step(1);

        // PERIOD = 0 auto-reload: overflow each tick
        tmr_ctrl = mk(1, 1, 0, 0, 0);
        step(2);
        chk("p0_pulse_a", ovf_pulse, 1);
        chk("p0_cntr_a", tmr_cntr, 0);
        step(1);
        chk("p0_pulse_b", ovf_pulse, 1);
        chk("p0_cntr_b", tmr_cntr, 0);
        tmr_ctrl = '0;
        step(1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
